// File: rtl/gshare_pht.sv
// gshare_pht: direction predictor for the fetch stage.
// Owns the speculative global history register handed to the BTB, predicts
// taken/not-taken from a table of 2-bit saturating counters indexed by the
// BTB index, trains those counters from execute-stage resolution and repairs
// the history on a misprediction. Also keeps resolved/mispredicted counts.
//
// Interface timing: there is no valid/ready handshake. A lookup
// (btb_hit/btb_idx) and an update (upd_en qualifying upd_*) are both
// accepted unconditionally every cycle. upd_mispred is meaningful only when
// upd_en is 1. pred_take/pred_ghr are combinational in the same cycle as the
// lookup.
module gshare_pht #(
   parameter int GHR_W   = 8,
   parameter int ENTRIES = 256,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             resetn,
   output logic [GHR_W-1:0] ghr_o,
   input  logic             btb_hit,
   input  logic [GHR_W-1:0] btb_idx,
   input  logic             fetch_adv,
   output logic             pred_take,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_en,
   input  logic [GHR_W-1:0] upd_idx,
   input  logic             upd_taken,
   input  logic             upd_mispred,
   input  logic [GHR_W-1:0] upd_ghr,
   output logic [CNT_W-1:0] pred_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [1:0] CNT_RESET = 2'b01;  // weakly not-taken

   logic [1:0]       cnt_q [ENTRIES];
   logic [GHR_W-1:0] ghr_q;
   logic [CNT_W-1:0] pred_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_q;
   logic [1:0]       rd_cnt;

   // One training step of a 2-bit saturating counter.
   function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
      logic [1:0] r;
      r = c;
      if (taken) begin
         if (c != 2'b11) r = c + 2'b01;
      end else begin
         if (c != 2'b00) r = c - 2'b01;
      end
      return r;
   endfunction

   // Lookup with same-cycle forwarding of an update to the same entry, so the
   // prediction matches what the BTB sees through its own write forwarding.
   always_comb begin
      rd_cnt = cnt_q[btb_idx];
      if (upd_en && (upd_idx == btb_idx)) rd_cnt = sat_step(cnt_q[btb_idx], upd_taken);
      pred_take = btb_hit & rd_cnt[1];
   end

   assign ghr_o       = ghr_q;
   assign pred_ghr    = ghr_q;
   assign pred_cnt    = pred_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

   // Counter table training; only the resolved entry moves.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
      end else if (upd_en) begin
         cnt_q[upd_idx] <= sat_step(cnt_q[upd_idx], upd_taken);
      end
   end

   // History: misprediction repair wins over the speculative shift, because
   // the fetch-side prediction in a repair cycle is being flushed anyway.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ghr_q <= '0;
      end else if (upd_en && upd_mispred) begin
         ghr_q <= {upd_ghr[GHR_W-2:0], upd_taken};
      end else if (fetch_adv && btb_hit) begin
         ghr_q <= {ghr_q[GHR_W-2:0], pred_take};
      end
   end

   // Performance counters; both wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else if (upd_en) begin
         pred_cnt_q <= pred_cnt_q + 1'b1;
         if (upd_mispred) mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
   end

endmodule
